// File: rtl/flit_requester.sv
// Credit-gated flit requester: buffers upstream flits in a small FIFO, requests a
// round-robin arbiter, and registers each granted flit with a priority-update on tails.
module flit_requester #(
  parameter int FLIT_W  = 34,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FLIT_W-1:0] in_flit_i,
  input  logic              in_last_i,
  output logic              req_o,
  input  logic              grant_i,
  output logic              update_o,
  output logic              out_valid_o,
  output logic [FLIT_W-1:0] out_flit_o,
  output logic              out_last_o,
  input  logic              credit_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [0:0] {IDLE = 1'b0, PKT = 1'b1} state_t;

  // Each entry holds {last, flit}.
  logic [FLIT_W:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              update_q, update_d;
  logic              out_last_q, out_last_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            send;
  logic [FLIT_W:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // Readiness and request are both masked during reset, so nothing moves then.
  assign in_ready_o = !full && !arst;
  assign req_o      = !empty && (credit_cnt_q != '0) && !arst;
  assign push       = in_valid_i && in_ready_o;
  assign send       = req_o && grant_i;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    credit_cnt_d = credit_cnt_q;
    state_d      = state_q;
    out_valid_d  = send;
    update_d     = send && head[FLIT_W];
    out_flit_d   = out_flit_q;
    out_last_d   = out_last_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (send) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      out_flit_d = head[FLIT_W-1:0];
      out_last_d = head[FLIT_W];
      state_d    = head[FLIT_W] ? IDLE : PKT;
    end

    // A returned credit in a send cycle cancels the decrement; otherwise saturate.
    if (send && !credit_i) begin
      credit_cnt_d = credit_cnt_q - CRED_ONE;
    end else if (!send && credit_i && (credit_cnt_q != CRED_MAX)) begin
      credit_cnt_d = credit_cnt_q + CRED_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      credit_cnt_q <= CRED_MAX;
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      update_q     <= 1'b0;
      out_flit_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      update_q     <= update_d;
      out_flit_q   <= out_flit_d;
      out_last_q   <= out_last_d;
    end
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {in_last_i, in_flit_i};
    end
  end

  assign out_valid_o = out_valid_q;
  assign update_o    = update_q;
  assign out_flit_o  = out_flit_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_flit_requester.sv
// Directed bench for flit_requester: a per-cycle vector table plus hand-written
// sequences for credit exhaustion, FIFO full, and mid-packet reset.
module tb_flit_requester;

  localparam int FW = 34;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [FW-1:0] in_flit_i = '0;
  logic          in_last_i = 1'b0;
  logic          req_o;
  logic          grant_i = 1'b0;
  logic          update_o;
  logic          out_valid_o;
  logic [FW-1:0] out_flit_o;
  logic          out_last_o;
  logic          credit_i = 1'b0;

  int checks = 0;
  int errors = 0;

  flit_requester #(.FLIT_W(FW), .DEPTH(4), .CREDITS(4)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_flit_i  (in_flit_i),
    .in_last_i  (in_last_i),
    .req_o      (req_o),
    .grant_i    (grant_i),
    .update_o   (update_o),
    .out_valid_o(out_valid_o),
    .out_flit_o (out_flit_o),
    .out_last_o (out_last_o),
    .credit_i   (credit_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vin;
    logic [FW-1:0] flit;
    logic          last;
    logic          grant;
    logic          cred;
    logic          e_rdy;
    logic          e_req;
    logic          e_ov;
    logic [FW-1:0] e_flit;
    logic          e_last;
    logic          e_upd;
    int            e_cnt;
    int            e_st;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic vin, input logic [FW-1:0] flit, input logic last,
                      input logic grant, input logic cred);
    @(negedge clk);
    in_valid_i = vin;
    in_flit_i  = flit;
    in_last_i  = last;
    grant_i    = grant;
    credit_i   = cred;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    in_valid_i = 1'b0;
    grant_i = 1'b1;
    credit_i = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_req", 64'(req_o), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    grant_i = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_update", 64'(update_o), 64'd0);
    chk("rst_out_flit", 64'(out_flit_o), 64'd0);
    chk("rst_credit", 64'(dut.credit_cnt_q), 64'd4);
  endtask

  initial begin
    int nsent;
    int acc;

    //               vin flit      l  g  c | rdy req ov e_flit    el up cnt st
    tbl[0]  = '{1'b1, 34'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 34'h0,  1'b0, 1'b0, 4, 0};
    tbl[1]  = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 34'h0,  1'b0, 1'b0, 4, 0};
    tbl[2]  = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 34'hA5, 1'b1, 1'b1, 3, 0};
    tbl[3]  = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 34'hA5, 1'b1, 1'b0, 3, 0};
    tbl[4]  = '{1'b1, 34'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 34'hA5, 1'b1, 1'b0, 3, 0};
    tbl[5]  = '{1'b1, 34'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 34'hA5, 1'b1, 1'b0, 3, 0};
    tbl[6]  = '{1'b1, 34'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 34'h11, 1'b0, 1'b0, 2, 1};
    tbl[7]  = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 34'h22, 1'b0, 1'b0, 1, 1};
    tbl[8]  = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 34'h33, 1'b1, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 34'h33, 1'b1, 1'b0, 0, 0};
    tbl[10] = '{1'b1, 34'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 34'h33, 1'b1, 1'b0, 1, 0};
    tbl[11] = '{1'b0, 34'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 34'h33, 1'b1, 1'b0, 1, 0};
    tbl[12] = '{1'b0, 34'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 34'h44, 1'b1, 1'b1, 1, 0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].vin, tbl[i].flit, tbl[i].last, tbl[i].grant, tbl[i].cred);
      $display("vec %0d: rdy=%0b req=%0b ov=%0b flit=%0h last=%0b upd=%0b cnt=%0d",
               i, in_ready_o, req_o, out_valid_o, out_flit_o, out_last_o, update_o,
               dut.credit_cnt_q);
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready_o), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_req", i), 64'(req_o), 64'(tbl[i].e_req));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid_o), 64'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_flit", i), 64'(out_flit_o), 64'(tbl[i].e_flit));
      chk($sformatf("v%0d_out_last", i), 64'(out_last_o), 64'(tbl[i].e_last));
      chk($sformatf("v%0d_update", i), 64'(update_o), 64'(tbl[i].e_upd));
      chk($sformatf("v%0d_credit", i), 64'(dut.credit_cnt_q), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_state", i), 64'(dut.state_q), 64'(tbl[i].e_st));
    end

    // Credit saturation: 1 -> 4, then an extra pulse must not overflow.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("saturate: cnt=%0d", dut.credit_cnt_q);
    chk("credit_saturate", 64'(dut.credit_cnt_q), 64'd4);

    // Six single-flit packets against four credits.
    do_reset();
    nsent = 0;
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      step(acc < 6, 34'(34'h100 + acc), 1'b1, 1'b1, 1'b0);
      if (out_valid_o) begin
        $display("credit seq send %0d: flit=%0h", nsent, out_flit_o);
        chk("credit_seq_data", 64'(out_flit_o), 64'(34'h100 + nsent));
        nsent++;
      end
      if (in_valid_i && in_ready_o) acc++;
    end
    chk("credit_sends_4", 64'(nsent), 64'd4);
    chk("credit_req_low", 64'(req_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (out_valid_o) begin
        $display("credit seq send %0d: flit=%0h", nsent, out_flit_o);
        chk("credit_seq_data", 64'(out_flit_o), 64'(34'h100 + nsent));
        nsent++;
      end
    end
    chk("credit_sends_5", 64'(nsent), 64'd5);
    chk("credit_empty_cnt", 64'(dut.credit_cnt_q), 64'd0);

    // Fill to full, pop in the full cycle, then drain and check order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 34'(34'h200 + i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("fill%0d_in_ready", i), 64'(in_ready_o), 64'd1);
    end
    nsent = 0;
    step(1'b1, 34'h204, 1'b1, 1'b1, 1'b0);
    $display("full cycle: rdy=%0b req=%0b", in_ready_o, req_o);
    chk("full_pop_in_ready", 64'(in_ready_o), 64'd0);
    chk("full_pop_req", 64'(req_o), 64'd1);
    step(1'b1, 34'h204, 1'b1, 1'b1, 1'b0);
    chk("after_pop_in_ready", 64'(in_ready_o), 64'd1);
    for (int c = 0; c < 12; c++) begin
      if (out_valid_o) begin
        $display("drain send %0d: flit=%0h", nsent, out_flit_o);
        chk("drain_data", 64'(out_flit_o), 64'(34'h200 + nsent));
        nsent++;
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end
    chk("drain_count", 64'(nsent), 64'd5);

    // Reset in mid-packet after the head flit has been sent.
    do_reset();
    step(1'b1, 34'h301, 1'b0, 1'b0, 1'b0);
    step(1'b1, 34'h302, 1'b0, 1'b0, 1'b0);
    step(1'b1, 34'h303, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("mid_req", 64'(req_o), 64'd1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(req_o), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("mid_head_out", 64'(out_flit_o), 64'h301);
    chk("mid_state_pkt", 64'(dut.state_q), 64'd1);
    @(negedge clk);
    arst = 1'b0;
    grant_i = 1'b0;
    #1;
    $display("post reset: req=%0b ov=%0b upd=%0b cnt=%0d", req_o, out_valid_o, update_o,
             dut.credit_cnt_q);
    chk("post_rst_req", 64'(req_o), 64'd0);
    chk("post_rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("post_rst_update", 64'(update_o), 64'd0);
    chk("post_rst_credit", 64'(dut.credit_cnt_q), 64'd4);
    chk("post_rst_state", 64'(dut.state_q), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready_o), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_empty_req", 64'(req_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flit_requester.md
FLIT_REQUESTER -- requirements
Module: flit_requester

Interface
REQ-001 SHALL have parameter FLIT_W, default 34, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, input FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter CREDITS, default 4, downstream buffer slots; >= 1.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port arst, input, 1, reset; synchronous, active-high, sampled on the clk rising edge only.
REQ-006 SHALL have port in_valid_i, input, 1, upstream flit valid.
REQ-007 SHALL have port in_ready_o, output, 1, FIFO can accept a flit.
REQ-008 SHALL have port in_flit_i, input, FLIT_W, upstream flit data.
REQ-009 SHALL have port in_last_i, input, 1, flit is the packet tail.
REQ-010 SHALL have port req_o, output, 1, request to the round-robin arbiter.
REQ-011 SHALL have port grant_i, input, 1, this requester's arbiter grant bit.
REQ-012 SHALL have port update_o, output, 1, arbiter priority-update pulse.
REQ-013 SHALL have port out_valid_o, output, 1, granted flit valid.
REQ-014 SHALL have port out_flit_o, output, FLIT_W, granted flit data.
REQ-015 SHALL have port out_last_o, output, 1, granted flit is the tail.
REQ-016 SHALL have port credit_i, input, 1, one-cycle pulse returning one downstream slot.

Function
REQ-017 SHALL accept a push when in_valid_i && in_ready_o; in_ready_o = !full; flit and last bit are stored together.
REQ-018 SHALL make a pushed flit eligible for request on the cycle after the push; there is no combinational bypass from in_flit_i.
REQ-019 SHALL drive req_o combinationally as !empty && (credit_cnt != 0).
REQ-020 SHALL treat the cycle req_o && grant_i as a send: pop the FIFO head at that edge and decrement credit_cnt.
REQ-021 SHALL ignore grant_i while req_o is low: no pop, no credit change, no output.
REQ-022 SHALL register the send: out_valid_o=1 with out_flit_o/out_last_o equal to the popped entry, exactly 1 cycle after the grant cycle.
REQ-023 SHALL register update_o=1 in the same cycle as out_valid_o when the sent flit has last=1, and 0 otherwise.
REQ-024 SHALL hold out_flit_o and out_last_o at their previous values when out_valid_o=0.
REQ-025 SHALL implement FSM IDLE/PKT: IDLE->PKT on a send with last=0; PKT->IDLE on a send with last=1; a single-flit packet (last=1 sent in IDLE) stays in IDLE.
REQ-026 SHALL, in PKT with the FIFO empty or no credit, drop req_o and remain in PKT; the packet resumes when both are available.
REQ-027 SHALL keep credit_cnt in [0, CREDITS]: a send decrements it, credit_i increments it, and a send plus credit_i in the same cycle leave it unchanged.
REQ-028 SHALL ignore credit_i when credit_cnt=CREDITS and no send occurs in that cycle (saturate).
REQ-029 SHALL allow a simultaneous push and pop when not full; occupancy is then unchanged and FIFO order is preserved.
REQ-030 SHALL keep in_ready_o low in a full cycle even if a pop occurs in that cycle.
REQ-031 SHALL wrap the read and write pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-032 SHALL, while arst=1 at a clk edge, clear the FIFO, set FSM=IDLE, set credit_cnt=CREDITS, out_valid_o=0, update_o=0, out_flit_o=0, out_last_o=0.
REQ-033 SHALL force in_ready_o and req_o to 0 in any cycle where arst=1.
REQ-034 SHALL, on reset in mid-packet, discard all buffered flits and suppress any pending out_valid_o/update_o at the next edge.

Verification
REQ-035 SHALL cover: push a single flit 0xA5 with last=1, grant_i held high -> req_o high the cycle after the push; out_valid_o=1, out_flit_o=0xA5, update_o=1 one cycle after the grant; credit_cnt=3.
REQ-036 SHALL cover: a 3-flit packet with grant_i held high -> three consecutive out_valid_o cycles, update_o only on the third, FSM back in IDLE.
REQ-037 SHALL cover: CREDITS=4 with 6 flits queued and no credit_i -> exactly 4 sends, then req_o=0; one credit_i pulse -> exactly one more send.
REQ-038 SHALL cover: fill to DEPTH=4 -> in_ready_o=0; a pop in the full cycle leaves in_ready_o=0, which is 1 the next cycle; data order is intact.
REQ-039 SHALL cover: grant_i=1 while empty -> no out_valid_o and no credit change; a send and credit_i in the same cycle -> credit_cnt unchanged.
REQ-040 SHALL cover: arst asserted after the head of a 3-flit packet -> next cycle FIFO empty, req_o=0, out_valid_o=0, credit_cnt=4, FSM=IDLE.
